// File: rtl/jtriders_iomux_if.sv
// rtl/jtriders_iomux_if.sv - CPU I/O bus bundle for jtriders_iomux
interface jtriders_iomux_if;
    logic       cs;
    logic       we;
    logic [7:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (
        output cs, we, addr, din,
        input  dout
    );

    modport slave (
        input  cs, we, addr, din,
        output dout
    );
endinterface

// File: rtl/jtriders_iomux.sv
// rtl/jtriders_iomux.sv - cabinet I/O read mux, coin/service debounce,
// timed object-DMA busy flag and coin counter/lockout latch
module jtriders_iomux #(
    parameter int PLAYERS = 4,
    parameter int DMA_LEN = 256,
    parameter int DEB_FR  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_cen,
    jtriders_iomux_if.slave        bus,
    input  logic                   LVBL,
    input  logic [2:0]             IPLn,
    input  logic                   eep_rdy,
    input  logic                   eep_do,
    input  logic                   dip_test,
    input  logic [PLAYERS*7-1:0]   joystick,
    input  logic [PLAYERS-1:0]     cab_1p,
    input  logic [PLAYERS-1:0]     coin,
    input  logic [PLAYERS-1:0]     service,
    output logic                   dma_busy,
    output logic [1:0]             coin_cnt,
    output logic [1:0]             coin_lock
);
    localparam int              NB        = 2 * PLAYERS;
    localparam logic [2:0]      DEB_LAST  = 3'(DEB_FR - 1);
    localparam logic [15:0]     DMA_LOAD  = 16'(DMA_LEN);

    logic [2:0]    sel;
    logic          wr;
    logic [NB-1:0] sync0, sync1, filt;
    logic [2:0]    deb_cnt [NB];
    logic          lvbl_l;
    logic          frame_tick;
    logic [15:0]   dma_cnt;
    logic [27:0]   joy_all;
    logic [3:0]    cab_all, coin_f, svc_f;
    logic [7:0]    rd_mux;
    logic          unused;

    assign sel        = {bus.addr[7], bus.addr[1:0]};
    assign wr         = bus.cs & bus.we & cpu_cen;
    assign frame_tick = lvbl_l & ~LVBL;
    assign dma_busy   = (dma_cnt != 16'd0);
    assign unused     = ^{IPLn[2:1], bus.addr[6:2], bus.din[7:4]};

    // Service bits sit above coin bits in the shared sync/filter vectors
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0  <= '1;
            sync1  <= '1;
            lvbl_l <= 1'b0;
        end else begin
            sync0  <= {service, coin};
            sync1  <= sync0;
            lvbl_l <= LVBL;
        end
    end

    // A bit flips only after DEB_FR consecutive frame samples disagree with it
    always_ff @(posedge clk) begin
        if (rst) begin
            filt <= '1;
            for (int i = 0; i < NB; i++) deb_cnt[i] <= 3'd0;
        end else if (frame_tick) begin
            for (int i = 0; i < NB; i++) begin
                if (sync1[i] == filt[i]) begin
                    deb_cnt[i] <= 3'd0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    filt[i]    <= sync1[i];
                    deb_cnt[i] <= 3'd0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 3'd1;
                end
            end
        end
    end

    // Absent players and filter bits read back as released (1)
    always_comb begin
        joy_all = '1;
        cab_all = '1;
        coin_f  = '1;
        svc_f   = '1;
        for (int i = 0; i < PLAYERS; i++) begin
            joy_all[i*7 +: 7] = joystick[i*7 +: 7];
            cab_all[i]        = cab_1p[i];
            coin_f[i]         = filt[i];
            svc_f[i]          = filt[PLAYERS + i];
        end
    end

    always_comb begin
        rd_mux = 8'hFF;
        case (sel)
            3'b000, 3'b001, 3'b010, 3'b011:
                rd_mux = {cab_all[sel[1:0]], joy_all[int'(sel[1:0])*7 +: 7]};
            3'b100, 3'b110:
                rd_mux = {svc_f, coin_f};
            default:
                rd_mux = {dip_test, 1'b1, 1'b1, IPLn[0], LVBL, dma_busy, eep_rdy, eep_do};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) bus.dout <= 8'hFF;
        else     bus.dout <= rd_mux;
    end

    // Trigger wins over the decrement, so a retrigger always restarts the full length
    always_ff @(posedge clk) begin
        if (rst) begin
            dma_cnt <= 16'd0;
        end else if (wr && sel == 3'b110) begin
            dma_cnt <= DMA_LOAD;
        end else if (cpu_cen && dma_cnt != 16'd0) begin
            dma_cnt <= dma_cnt - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coin_cnt  <= 2'b00;
            coin_lock <= 2'b00;
        end else if (wr && sel == 3'b111) begin
            coin_cnt  <= bus.din[1:0];
            coin_lock <= bus.din[3:2];
        end
    end
endmodule

// File: tb/tb_jtriders_iomux.sv
// tb/tb_jtriders_iomux.sv - scoreboard bench for jtriders_iomux
module tb_jtriders_iomux;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst_b, cpu_cen, LVBL, eep_rdy, eep_do, dip_test;
    logic [2:0]  IPLn;
    logic [13:0] joystick;
    logic [1:0]  cab_1p, coin, service;
    logic [27:0] joystick_b;
    logic [3:0]  cab_b, coin_b, service_b;
    logic        dma_busy, dma_busy_b;
    logic [1:0]  coin_cnt, coin_lock, coin_cnt_b, coin_lock_b;

    jtriders_iomux_if bus ();
    jtriders_iomux_if bus_b ();

    jtriders_iomux #(.PLAYERS(2), .DMA_LEN(4), .DEB_FR(2)) dut (
        .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .bus(bus),
        .LVBL(LVBL), .IPLn(IPLn), .eep_rdy(eep_rdy), .eep_do(eep_do),
        .dip_test(dip_test), .joystick(joystick), .cab_1p(cab_1p),
        .coin(coin), .service(service), .dma_busy(dma_busy),
        .coin_cnt(coin_cnt), .coin_lock(coin_lock)
    );

    jtriders_iomux #(.PLAYERS(4), .DMA_LEN(200), .DEB_FR(1)) dut_b (
        .clk(clk), .rst(rst_b), .cpu_cen(cpu_cen), .bus(bus_b),
        .LVBL(LVBL), .IPLn(IPLn), .eep_rdy(eep_rdy), .eep_do(eep_do),
        .dip_test(dip_test), .joystick(joystick_b), .cab_1p(cab_b),
        .coin(coin_b), .service(service_b), .dma_busy(dma_busy_b),
        .coin_cnt(coin_cnt_b), .coin_lock(coin_lock_b)
    );

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] val;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] probe(input int s);
        case (s)
            0:       return bus.dout;
            1:       return {7'd0, dma_busy};
            2:       return {6'd0, coin_cnt};
            3:       return {6'd0, coin_lock};
            4:       return bus_b.dout;
            default: return {7'd0, dma_busy_b};
        endcase
    endfunction

    // Monitor: every expectation due this cycle is compared on the falling edge
    always @(negedge clk) begin
        logic [7:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                total++;
                act = probe(sb[i].sel);
                if (act !== sb[i].val) begin
                    bad++;
                    $display("FAIL %s: got %h want %h (cycle %0d)", sb[i].name, act, sb[i].val, cyc);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL %s: check missed (due cycle %0d)", sb[i].name, sb[i].cyc);
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input string name, input int s, input logic [7:0] v, input int dly);
        sb.push_back('{name, s, v, cyc + dly});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit to_b, input logic [7:0] a, input logic [7:0] d);
        if (to_b) begin
            bus_b.cs = 1'b1; bus_b.we = 1'b1; bus_b.addr = a; bus_b.din = d;
        end else begin
            bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.din = d;
        end
        tick(1);
        bus.cs = 1'b0;   bus.we = 1'b0;   bus.addr = 8'h81;
        bus_b.cs = 1'b0; bus_b.we = 1'b0;
    endtask

    task automatic frame();
        LVBL = 1'b0;
        tick(4);
        LVBL = 1'b1;
        tick(4);
    endtask

    logic [7:0] rd_addr [4] = '{8'h01, 8'h00, 8'h02, 8'h03};
    logic [7:0] rd_exp  [4] = '{8'h55, 8'hAA, 8'hFF, 8'hFF};
    logic [7:0] rdb_addr[3] = '{8'h03, 8'h02, 8'h00};
    logic [7:0] rdb_exp [3] = '{8'h12, 8'hB3, 8'hFF};

    initial begin
        int n;
        rst = 1'b1; rst_b = 1'b1; cpu_cen = 1'b1; LVBL = 1'b1;
        IPLn = 3'b111; eep_rdy = 1'b1; eep_do = 1'b0; dip_test = 1'b1;
        joystick = {7'h55, 7'h2A}; cab_1p = 2'b01; coin = 2'b11; service = 2'b11;
        joystick_b = {7'h12, 7'h33, 7'h7F, 7'h7F}; cab_b = 4'b0111;
        coin_b = 4'hF; service_b = 4'hF;
        bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 8'h00; bus.din = 8'h00;
        bus_b.cs = 1'b0; bus_b.we = 1'b0; bus_b.addr = 8'h00; bus_b.din = 8'h00;
        tick(3);
        rst = 1'b0; rst_b = 1'b0;

        expect_at("rst_dout", 0, 8'hFF, 0);
        expect_at("rst_busy", 1, 8'h00, 0);
        expect_at("rst_cnt",  2, 8'h00, 0);
        expect_at("rst_lock", 3, 8'h00, 0);
        expect_at("rst_dout_b", 4, 8'hFF, 0);
        bus.addr = 8'h80;
        expect_at("rd_s4_reset", 0, 8'hFF, 1);
        tick(1);

        for (int i = 0; i < 4; i++) begin
            bus.addr = rd_addr[i];
            expect_at($sformatf("rd_player_s%0d", rd_addr[i][1:0]), 0, rd_exp[i], 1);
            tick(1);
        end
        for (int i = 0; i < 3; i++) begin
            bus_b.addr = rdb_addr[i];
            expect_at($sformatf("b_rd_player_s%0d", rdb_addr[i][1:0]), 4, rdb_exp[i], 1);
            tick(1);
        end

        bus.addr = 8'h81;
        expect_at("status_idle", 0, 8'hFA, 1);
        tick(1);
        IPLn = 3'b110; eep_do = 1'b1; dip_test = 1'b0;
        expect_at("status_alt", 0, 8'h6B, 1);
        tick(1);
        IPLn = 3'b111; eep_do = 1'b0; dip_test = 1'b1;
        expect_at("status_back", 0, 8'hFA, 1);
        tick(1);

        // Single trigger: busy high for exactly 4 ticks
        expect_at("dma_pre", 1, 8'h00, 0);
        for (int d = 1; d <= 4; d++) expect_at($sformatf("dma_busy_t%0d", d), 1, 8'h01, d);
        expect_at("dma_done", 1, 8'h00, 5);
        expect_at("dma_rd_s6", 0, 8'hFF, 1);
        for (int d = 2; d <= 5; d++) expect_at($sformatf("dma_status_t%0d", d), 0, 8'hFE, d);
        expect_at("dma_status_done", 0, 8'hFA, 6);
        wr(1'b0, 8'h82, 8'hA5);
        tick(6);

        // Retrigger two ticks in: six busy ticks in all
        for (int d = 1; d <= 6; d++) expect_at($sformatf("retrig_t%0d", d), 1, 8'h01, d);
        expect_at("retrig_done", 1, 8'h00, 7);
        wr(1'b0, 8'h82, 8'h00);
        tick(1);
        wr(1'b0, 8'h82, 8'h00);
        tick(7);

        // Retrigger on the final decrement reloads
        for (int d = 1; d <= 8; d++) expect_at($sformatf("lastdec_t%0d", d), 1, 8'h01, d);
        expect_at("lastdec_done", 1, 8'h00, 9);
        wr(1'b0, 8'h82, 8'h00);
        tick(3);
        wr(1'b0, 8'h82, 8'h00);
        tick(9);

        expect_at("coin_cnt_pre", 2, 8'h00, 0);
        expect_at("coin_cnt_wr",  2, 8'h02, 1);
        expect_at("coin_lock_wr", 3, 8'h03, 1);
        wr(1'b0, 8'h83, 8'h0E);
        expect_at("coin_cnt_nocen",  2, 8'h02, 1);
        expect_at("coin_lock_nocen", 3, 8'h03, 1);
        cpu_cen = 1'b0;
        wr(1'b0, 8'h83, 8'h05);
        cpu_cen = 1'b1;
        expect_at("coin_cnt_wr2",  2, 8'h01, 1);
        expect_at("coin_lock_wr2", 3, 8'h01, 1);
        wr(1'b0, 8'h83, 8'h05);
        tick(2);

        bus.addr = 8'h80; bus_b.addr = 8'h80;
        coin[0] = 1'b0;
        tick(3);
        frame();
        expect_at("deb_one_low", 0, 8'hFF, 0);
        coin[0] = 1'b1;
        tick(3);
        frame();
        expect_at("deb_glitch", 0, 8'hFF, 0);
        expect_at("b_deb_idle", 4, 8'hFF, 0);

        coin[0] = 1'b0; coin_b[3] = 1'b0;
        tick(3);
        frame();
        expect_at("deb_first_of_two", 0, 8'hFF, 0);
        expect_at("b_deb_one_frame", 4, 8'hF7, 0);
        LVBL = 1'b0;
        expect_at("deb_second_fall_pre", 0, 8'hFF, 1);
        expect_at("deb_second_fall", 0, 8'hFE, 2);
        tick(4);
        LVBL = 1'b1;
        tick(4);

        service[1] = 1'b0;
        tick(3);
        frame();
        frame();
        expect_at("deb_service", 0, 8'hDE, 0);

        // Reset partway through a debounce discards the partial count
        coin[1] = 1'b0;
        tick(3);
        frame();
        rst = 1'b1;
        tick(1);
        expect_at("rst_deb_dout", 0, 8'hFF, 0);
        expect_at("rst_coin_cnt", 2, 8'h00, 0);
        rst = 1'b0;
        tick(3);
        frame();
        expect_at("deb_after_rst_1", 0, 8'hFF, 0);
        frame();
        expect_at("deb_after_rst_2", 0, 8'hDC, 0);

        wr(1'b1, 8'h82, 8'h00);
        tick(100);
        expect_at("b_busy_at100", 5, 8'h01, 0);
        rst_b = 1'b1;
        expect_at("b_rst_busy", 5, 8'h00, 1);
        tick(1);
        rst_b = 1'b0;
        expect_at("b_busy_idle", 5, 8'h00, 0);
        expect_at("b_busy_first", 5, 8'h01, 1);
        expect_at("b_busy_last", 5, 8'h01, 200);
        expect_at("b_busy_done", 5, 8'h00, 201);
        wr(1'b1, 8'h82, 8'h00);
        tick(202);

        tick(3);
        n = sb.size();
        if (n != 0) begin
            bad += n;
            total += n;
            $display("FAIL leftover: %0d checks never reached, want 0", n);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/jtriders_iomux.md
# jtriders_iomux

Parametrised cabinet I/O block for the Riders-family cores: multiplexes up to four player ports, debounced coin/service inputs and a system status byte onto the 68000 read bus. It also emulates the object-DMA busy flag with a programmable-length countdown, and latches coin-counter/lockout writes. It sits between the CPU address decoder and the cabinet input/EEPROM signals, replacing the single-toggle fake DMA flag with a timed one.

## Interface
Parameters:
- PLAYERS, 4, number of player ports implemented (1..4); absent ports read 8'hFF
- DMA_LEN, 256, busy duration in cpu_cen ticks after a DMA trigger write (1..65535)
- DEB_FR, 2, consecutive equal frame samples required to accept a coin/service change (1..7)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cpu_cen  in  1  CPU clock enable
- cs  in  1  I/O area select (active high)
- we  in  1  write strobe, valid with cs
- addr  in  8  CPU address bits [8:1]
- din  in  8  CPU write data, low byte
- LVBL  in  1  vertical blank, active low
- IPLn  in  3  interrupt level lines; only bit 0 is reported
- eep_rdy, eep_do  in  1 each  EEPROM status
- dip_test  in  1  test DIP, active low
- joystick  in  PLAYERS*7  packed joysticks, player 0 in bits [6:0], active low
- cab_1p  in  PLAYERS  start buttons, active low
- coin, service  in  PLAYERS each  raw active-low inputs
- dout  out  8  registered read data
- dma_busy  out  1  emulated DMA busy
- coin_cnt  out  2  coin counter drives
- coin_lock  out  2  coin lockout drives

## Operation
- Read select s = {addr[8], addr[2:1]}.
- s=0..3: player s reads {cab_1p[s], joystick[s*7+:7]}; for s >= PLAYERS, reads 8'hFF.
- addr[8]=1, addr[1]=0: reads {svc_f[3:0], coin_f[3:0]} (filtered); unimplemented bits read 1.
- addr[8]=1, addr[1]=1: reads {dip_test, 1, 1, IPLn[0], LVBL, dma_busy, eep_rdy, eep_do}.
- Coin/service filter:
  - Raw inputs pass through a 2-FF synchroniser.
  - Sampled once per frame, on the clk after LVBL falls.
  - The filtered bit takes the new value only after DEB_FR consecutive samples agree. The per-bit 3-bit counter resets on any disagreement.
- Writes are accepted only when cs & we & cpu_cen:
  - s=3'b110: DMA trigger. Loads the busy counter with DMA_LEN; din is ignored.
  - s=3'b111: coin_cnt <= din[1:0], coin_lock <= din[3:2].
  - Other write addresses have no effect.
- DMA counter:
  - 16 bits; decrements by 1 on each cpu_cen while nonzero.
  - dma_busy = (counter != 0).
  - A trigger while busy reloads DMA_LEN; it does not add to the remaining count.
  - A trigger on the same cycle as the final decrement also reloads.

## Timing
- Reset values: dout=8'hFF, dma_busy=0 (counter 0), coin_cnt=0, coin_lock=0, coin_f/svc_f all 1, filter counters 0, synchronisers 1.
- dout updates every clk, independent of cpu_cen and cs. Latency is 1 clk from addr or input change; sampled inputs are the unfiltered ones.
- Filtered coin latency: 2 clk sync + up to DEB_FR frames.
- dma_busy rises 1 clk after the trigger-write clk. It stays high for exactly DMA_LEN cpu_cen ticks, then falls on the clk of the final decrement.
- coin_cnt/coin_lock change 1 clk after the write clk and hold until the next write or reset.
- rst mid-DMA clears the counter immediately; dma_busy=0 on the next clk.
- rst mid-debounce discards partial counts.

## Test plan
- Reset: after rst, dout=FF, dma_busy=0, coin_cnt=0, coin_lock=0. Read s=4 -> 8'hFF.
- PLAYERS=2, joystick P1=7'h55, cab_1p[1]=0: s=1 -> 8'h55; s=2 and s=3 -> 8'hFF.
- DMA_LEN=4:
  - Trigger write, then poll status: bit 2 =1 for 4 cpu_cen ticks, then 0.
  - Retrigger at tick 2 -> busy lasts 6 ticks total.
- DEB_FR=2:
  - coin[0] low for 1 frame then high -> coin_f[0] stays 1.
  - Low for 2 frames -> s=4 bit 0 reads 0 after the second LVBL fall.
- Write din=8'h0E to s=7 -> coin_cnt=2'b10, coin_lock=2'b11.
  - A write with cpu_cen=0 -> no change.
- Assert rst with counter at 100 -> dma_busy=0 next clk; a subsequent trigger runs the full DMA_LEN.
